// File: rtl/reaction_responder_pkg.sv
// Shared definitions for the reaction-time auto-responder: FSM states,
// mode codes, LFSR seed and the BCD helpers used at load time.
package reaction_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LED = 3'd1,
    ST_COUNT    = 3'd2,
    ST_PRESS    = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Mode codes; 2'b11 is folded onto MODE_NORMAL when sampled
  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_FALSE  = 2'b01;
  localparam logic [1:0] MODE_NONE   = 2'b10;

  localparam logic [7:0]  LFSR_SEED = 8'hA5;
  localparam logic [11:0] BCD_MAX   = 12'h999;

  // True when all three nibbles are legal BCD digits
  function automatic logic bcd_digits_valid(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Adds a binary 0..15 jitter to a valid 3-digit BCD value, clamping at 999
  function automatic logic [11:0] bcd_add_sat(input logic [11:0] a, input logic [3:0] j);
    logic [3:0] j_tens;
    logic [3:0] j_units;
    logic [4:0] u;
    logic [4:0] t;
    logic [4:0] h;
    logic       cu;
    logic       ct;
    j_tens  = (j >= 4'd10) ? 4'd1 : 4'd0;
    j_units = (j >= 4'd10) ? (j - 4'd10) : j;
    u  = {1'b0, a[3:0]} + {1'b0, j_units};
    cu = (u > 5'd9);
    if (cu) u = u - 5'd10;
    t  = {1'b0, a[7:4]} + {1'b0, j_tens} + {4'd0, cu};
    ct = (t > 5'd9);
    if (ct) t = t - 5'd10;
    h  = {1'b0, a[11:8]} + {4'd0, ct};
    if (h > 5'd9) return BCD_MAX;
    return {h[3:0], t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/reaction_responder_bcd3_down.sv
// Three-digit BCD down counter holding the remaining response delay in ms.
// Loads take priority over decrements, and a count of 000 never wraps.
module bcd3_down
  import reaction_responder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [11:0] load_value,
  input  logic        dec,
  output logic        zero,
  output logic        load_valid
);

  logic [11:0] value;
  logic [11:0] dec_value;

  // Next value after one ms: borrow ripples from units through tens into hundreds
  always_comb begin
    dec_value = value;
    if (value[3:0] != 4'd0) begin
      dec_value[3:0] = value[3:0] - 4'd1;
    end else begin
      dec_value[3:0] = 4'd9;
      if (value[7:4] != 4'd0) begin
        dec_value[7:4] = value[7:4] - 4'd1;
      end else begin
        dec_value[7:4]  = 4'd9;
        dec_value[11:8] = value[11:8] - 4'd1;
      end
    end
  end

  // Counter register: load wins, decrement stops at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= 12'h000;
    end else if (load) begin
      value <= load_value;
    end else if (dec && !zero) begin
      value <= dec_value;
    end
  end

  assign zero       = (value == 12'h000);
  assign load_valid = bcd_digits_valid(load_value);

endmodule

// File: rtl/reaction_responder.sv
// Automatic test subject for the reaction-time tester: waits for the LED,
// counts a programmed BCD delay in ms ticks, then presses measure for a
// fixed number of ticks. Also fakes false starts and missing responses.
module reaction_responder
  import reaction_responder_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int PULSE_MS  = 20,
  parameter int JITTER_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        led,
  input  logic [11:0] delay_bcd,
  input  logic [1:0]  mode,
  output logic        measure,
  output logic        busy,
  output logic        done,
  output logic        invalid
);

  localparam int DIV   = CLK_HZ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(DIV - 1);
  localparam logic [7:0]       PULSE_LAST = 8'(PULSE_MS - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [7:0]       lfsr;
  logic [3:0]       jitter;
  logic [11:0]      load_value;
  logic [1:0]       mode_eff;
  logic [1:0]       mode_q;
  logic             led_q;
  logic             led_rise;
  logic             led_fall;
  logic [7:0]       pulse_cnt;
  logic             cnt_zero;
  logic             load_valid;
  logic             cnt_dec;
  state_t           state;
  state_t           next_state;
  logic             measure_next;
  logic             busy_next;
  logic             done_next;

  // Millisecond prescaler, restarted by every arm so tick phase is tied to start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (start || (pre_cnt == PRE_LAST)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  assign tick = (pre_cnt == PRE_LAST) && !start;

  // Free-running Fibonacci LFSR (x^8+x^6+x^5+x^4+1) supplying 0..15 ms of jitter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign jitter   = (JITTER_EN != 0) ? lfsr[3:0] : 4'd0;
  assign mode_eff = (mode == 2'b11) ? MODE_NORMAL : mode;

  // A bad delay is passed through untouched so the counter's digit check flags it
  assign load_value = bcd_digits_valid(delay_bcd) ? bcd_add_sat(delay_bcd, jitter) : delay_bcd;

  assign cnt_dec = tick && (state == ST_COUNT);

  bcd3_down u_count (
    .clk        (clk),
    .reset      (reset),
    .load       (start),
    .load_value (load_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero),
    .load_valid (load_valid)
  );

  // LED history; cleared on arm so an LED already lit after arming reads as a rising edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= 1'b0;
    end else if (start) begin
      led_q <= 1'b0;
    end else begin
      led_q <= led;
    end
  end

  assign led_rise = led && !led_q;
  assign led_fall = !led && led_q;

  // Per-sequence settings latched on arm: mode and the sticky bad-digit flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= MODE_NORMAL;
      invalid <= 1'b0;
    end else if (start) begin
      mode_q  <= mode_eff;
      invalid <= !load_valid;
    end
  end

  // Counts ms ticks while the press is held; idles at zero outside PRESS
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_cnt <= 8'd0;
    end else if (state != ST_PRESS) begin
      pulse_cnt <= 8'd0;
    end else if (tick) begin
      pulse_cnt <= pulse_cnt + 8'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic; an arm pulse overrides whatever the sequence is doing
  always_comb begin
    next_state = state;
    if (start) begin
      if (!load_valid) begin
        next_state = ST_DONE;
      end else if (mode_eff == MODE_FALSE) begin
        next_state = ST_COUNT;
      end else begin
        next_state = ST_WAIT_LED;
      end
    end else begin
      case (state)
        ST_IDLE: next_state = ST_IDLE;
        ST_WAIT_LED: begin
          if ((mode_q != MODE_NONE) && led_rise) next_state = ST_COUNT;
        end
        ST_COUNT: begin
          if ((mode_q == MODE_NORMAL) && led_fall) begin
            next_state = ST_IDLE;
          end else if (cnt_zero) begin
            next_state = ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (tick && (pulse_cnt == PULSE_LAST)) next_state = ST_DONE;
        end
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // FSM output decode, taken from the next state so the outputs can be registered
  always_comb begin
    measure_next = (next_state == ST_PRESS);
    busy_next    = (next_state == ST_WAIT_LED) || (next_state == ST_COUNT) ||
                   (next_state == ST_PRESS);
    done_next    = (next_state == ST_DONE);
  end

  // Registered outputs so the tester sees glitch-free levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      measure <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      measure <= measure_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

endmodule

// File: tb/tb_reaction_responder.sv
// Bench for reaction_responder at CLK_HZ=10_000 (one ms tick = 10 clk).
// Directed scenarios plus a randomized batch, checked against timing
// computed from the tick-grid rules rather than from the RTL.
module tb_reaction_responder;

  logic        clk;
  logic        reset;
  logic        start;
  logic        led;
  logic [11:0] delay_bcd;
  logic [1:0]  mode;
  logic        measure;
  logic        busy;
  logic        done;
  logic        invalid;

  logic        start_j;
  logic        led_j;
  logic [11:0] delay_j;
  logic [1:0]  mode_j;
  logic        measure_j;
  logic        busy_j;
  logic        done_j;
  logic        invalid_j;

  int total;
  int bad;
  logic [7:0] m_lfsr;

  reaction_responder #(.CLK_HZ(10_000), .PULSE_MS(20), .JITTER_EN(0)) dut (
    .clk(clk), .reset(reset), .start(start), .led(led), .delay_bcd(delay_bcd),
    .mode(mode), .measure(measure), .busy(busy), .done(done), .invalid(invalid)
  );

  reaction_responder #(.CLK_HZ(10_000), .PULSE_MS(20), .JITTER_EN(1)) dut_j (
    .clk(clk), .reset(reset), .start(start_j), .led(led_j), .delay_bcd(delay_j),
    .mode(mode_j), .measure(measure_j), .busy(busy_j), .done(done_j), .invalid(invalid_j)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference jitter source: the LFSR sequence from seed A5, one step per clock
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Hard stop in case a sequence never completes
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [11:0] d, input logic [1:0] m);
    delay_bcd = d;
    mode      = m;
    start     = 1'b1;
    tick_clk(1);
    start     = 1'b0;
  endtask

  task automatic wait_level(input logic lvl, input int budget, output int n);
    n = 0;
    while (measure !== lvl && n < budget) begin
      tick_clk(1);
      n++;
    end
  endtask

  // Edges from the arming edge until measure is seen high
  function automatic int exp_latency(input int d, input int l, input bit false_start);
    int k0;
    if (false_start) return 10 * d + 1;
    if (d == 0) return l + 2;
    k0 = (l + 2 + 9) / 10;
    return 10 * (k0 + d - 1) + 1;
  endfunction

  // Edges measure stays high when it rose p edges after arming (20 ms pulse)
  function automatic int exp_width(input int p);
    int t1;
    t1 = (p / 10 + 1) * 10;
    return t1 + 190 - p;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Normal-mode sequence: arm, light LED after l edges, check latency, width and done
  task automatic run_normal(input string tag, input int d, input int l, input logic [1:0] m);
    int n;
    int w;
    int p;
    led = 1'b0;
    apply_stimulus(to_bcd(d), m);
    tick_clk(l);
    led = 1'b1;
    wait_level(1'b1, 12000, n);
    p = l + n;
    check_output({tag, "_latency"}, p, exp_latency(d, l, 1'b0));
    check_output({tag, "_busy"}, busy, 1);
    led = 1'b0;
    wait_level(1'b0, 400, w);
    check_output({tag, "_width"}, w, exp_width(p));
    check_output({tag, "_done"}, done, 1);
    tick_clk(1);
    check_output({tag, "_done_end"}, {busy, done}, 0);
  endtask

  initial begin
    int n;
    int w;
    int hits;
    int dn;
    int j;
    int exp_n;
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; led = 1'b0; delay_bcd = 12'h000; mode = 2'b00;
    start_j = 1'b0; led_j = 1'b0; delay_j = 12'h998; mode_j = 2'b01;
    tick_clk(3);
    $display("[TB] reset state");
    check_output("reset_outputs", {measure, busy, done, invalid}, 0);
    check_output("reset_outputs_j", {measure_j, busy_j, done_j, invalid_j}, 0);
    reset = 1'b0;
    tick_clk(4);

    $display("[TB] normal delay 025, led after 30");
    run_normal("t1", 25, 30, 2'b00);
    tick_clk(5);

    $display("[TB] zero delay");
    led = 1'b0;
    apply_stimulus(12'h000, 2'b00);
    tick_clk(7);
    led = 1'b1;
    wait_level(1'b1, 50, n);
    check_output("t2_zero_latency", n, 2);
    led = 1'b0;
    wait_level(1'b0, 400, w);
    check_output("t2_zero_width", w, exp_width(9));
    tick_clk(5);

    $display("[TB] false start");
    apply_stimulus(12'h003, 2'b01);
    wait_level(1'b1, 200, n);
    check_output("t3_false_latency", n, 31);
    wait_level(1'b0, 400, w);
    check_output("t3_false_width", w, exp_width(31));
    check_output("t3_false_done", done, 1);
    tick_clk(5);

    $display("[TB] abort mid-count");
    apply_stimulus(12'h050, 2'b00);
    tick_clk(5);
    led = 1'b1;
    tick_clk(40);
    check_output("t4_abort_busy_before", busy, 1);
    led = 1'b0;
    tick_clk(2);
    check_output("t4_abort_idle", {busy, done}, 0);
    hits = 0; dn = 0;
    for (int i = 0; i < 600; i++) begin
      tick_clk(1);
      if (measure === 1'b1) hits++;
      if (done === 1'b1) dn++;
    end
    check_output("t4_abort_no_measure", hits, 0);
    check_output("t4_abort_no_done", dn, 0);

    $display("[TB] no response");
    apply_stimulus(12'h005, 2'b10);
    tick_clk(3);
    led = 1'b1;
    hits = 0;
    for (int i = 0; i < 20000; i++) begin
      tick_clk(1);
      if (measure === 1'b1) hits++;
    end
    check_output("t4_none_no_measure", hits, 0);
    check_output("t4_none_busy", busy, 1);

    $display("[TB] invalid digit");
    apply_stimulus(12'h0A5, 2'b00);
    check_output("t5_invalid_flags", {done, invalid, busy}, 3'b110);
    tick_clk(1);
    check_output("t5_invalid_after", {done, invalid}, 2'b01);
    led = 1'b0;
    hits = 0;
    for (int i = 0; i < 300; i++) begin
      tick_clk(1);
      if (measure === 1'b1) hits++;
    end
    check_output("t5_invalid_no_measure", hits, 0);

    $display("[TB] re-arm during press");
    apply_stimulus(12'h002, 2'b01);
    check_output("t6_invalid_cleared", invalid, 0);
    wait_level(1'b1, 100, n);
    check_output("t6_first_latency", n, 21);
    tick_clk(5);
    apply_stimulus(12'h003, 2'b01);
    check_output("t6_measure_drop", measure, 0);
    wait_level(1'b1, 100, n);
    check_output("t6_reload_latency", n, 31);
    wait_level(1'b0, 400, w);
    check_output("t6_reload_width", w, exp_width(31));

    $display("[TB] jitter saturation with 998");
    for (int i = 0; i < 64 && m_lfsr[3:0] < 4'd2; i++) tick_clk(1);
    j = int'(m_lfsr[3:0]);
    exp_n = 10 * ((998 + j > 999) ? 999 : 998 + j) + 1;
    start_j = 1'b1;
    tick_clk(1);
    start_j = 1'b0;
    n = 0;
    while (measure_j !== 1'b1 && n < 10100) begin
      tick_clk(1);
      n++;
    end
    check_output("t5_sat_latency", n, exp_n);
    check_output("t5_sat_invalid", invalid_j, 0);

    $display("[TB] randomized normal sequences");
    for (int k = 0; k < 8; k++) begin
      int d;
      int l;
      logic [1:0] m;
      d = $urandom_range(0, 39);
      l = $urandom_range(1, 25);
      m = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
      tick_clk(3);
      run_normal($sformatf("rnd%0d", k), d, l, m);
    end

    $display("[TB] async reset mid-count");
    tick_clk(3);
    apply_stimulus(12'h050, 2'b01);
    tick_clk(100);
    check_output("t6_reset_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check_output("t6_reset_immediate", {measure, busy, done, invalid}, 0);
    tick_clk(2);
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 700; i++) begin
      tick_clk(1);
      if (measure === 1'b1 || busy === 1'b1) hits++;
    end
    check_output("t6_reset_stays_idle", hits, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
